// File: rtl/mem_align_unit_pkg.sv
// mem_align_unit_pkg: shared width defaults, size/state encodings and
// lane helpers for the load/store alignment unit.
package mem_align_unit_pkg;

  localparam int unsigned AWIDTH_DEF = 10;
  localparam int unsigned DWIDTH     = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_FIN
  } state_e;

  // Right-justified byte mask for an access of the given size.
  function automatic logic [3:0] size_mask(input size_e sz);
    case (sz)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when off + n runs past the end of the word.
  function automatic logic is_split(input logic [1:0] off, input size_e sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return ({1'b0, off} + n) > 3'd4;
  endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// mem_align_unit_if: request/response handshake between MemoryAccess control
// (master) and the alignment unit (slave).
//   req_*  : byte-addressed request, transferred on req_valid && req_ready
//   rsp_*  : one-cycle completion pulse with load data / error flag
interface mem_align_unit_if #(
  parameter int unsigned AWIDTH = mem_align_unit_pkg::AWIDTH_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [AWIDTH+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_align_unit_lane.sv
// mem_lane_align: combinational lane steering shared by stores and loads.
//   off, size     : byte offset within word and access size
//   second        : 1 selects the lane mask of the second (W+1) access
//   st_data       : right-justified store data -> st_wdata (rotated), st_mask
//   ld_word0/1    : first word and low 3 bytes of the second word
//   ld_unsigned   : zero-extend when 1, sign-extend when 0 -> ld_data
module mem_lane_align
  import mem_align_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        second,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word0,
  input  logic [23:0] ld_word1,
  output logic [31:0] ld_data
);

  logic [7:0]  mask8;
  logic [31:0] sel;
  logic        sfill;

  always_comb begin
    // Mask spanning two words; upper nibble belongs to the second access.
    mask8   = {4'b0000, size_mask(size)} << off;
    st_mask = second ? mask8[7:4] : mask8[3:0];

    case (off)
      2'd0:    st_wdata = st_data;
      2'd1:    st_wdata = {st_data[23:0], st_data[31:24]};
      2'd2:    st_wdata = {st_data[15:0], st_data[31:16]};
      default: st_wdata = {st_data[7:0],  st_data[31:8]};
    endcase

    case (off)
      2'd0:    sel = ld_word0;
      2'd1:    sel = {ld_word1[7:0],  ld_word0[31:8]};
      2'd2:    sel = {ld_word1[15:0], ld_word0[31:16]};
      default: sel = {ld_word1[23:0], ld_word0[31:24]};
    endcase

    sfill = 1'b0;
    case (size)
      SZ_B: begin
        sfill   = ~ld_unsigned & sel[7];
        ld_data = {{24{sfill}}, sel[7:0]};
      end
      SZ_H: begin
        sfill   = ~ld_unsigned & sel[15];
        ld_data = {{16{sfill}}, sel[15:0]};
      end
      default: ld_data = sel;
    endcase
  end

endmodule

// File: rtl/mem_align_unit.sv
// mem_align_unit: byte/half/word alignment between MemoryAccess control and a
// byte-write-enable RAM with 1-cycle registered read.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : request/response handshake (slave side)
//   ram_addr   : word address, held when idle
//   ram_we     : per-byte write enable
//   ram_wdata  : lane-aligned write data
//   ram_rdata  : read data, one cycle after ram_addr
module mem_align_unit
  import mem_align_unit_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_align_unit_if.slave   bus,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [AWIDTH+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_buf_q, lo_buf_d;
  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [AWIDTH-1:0] word_w;
  logic [1:0]        off;
  logic              split;
  logic              acc_second;
  logic [31:0]       st_wdata;
  logic [3:0]        st_mask;
  logic [31:0]       ld_word0;
  logic [31:0]       ld_data;

  assign word_w   = addr_q[AWIDTH+1:2];
  assign off      = addr_q[1:0];
  assign split    = is_split(off, size_q);
  assign ld_word0 = split ? lo_buf_q : ram_rdata;

  mem_lane_align u_lane (
    .off         (off),
    .size        (size_q),
    .second      (acc_second),
    .st_data     (wdata_q),
    .st_wdata    (st_wdata),
    .st_mask     (st_mask),
    .ld_unsigned (uns_q),
    .ld_word0    (ld_word0),
    .ld_word1    (ram_rdata[23:0]),
    .ld_data     (ld_data)
  );

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_buf_d    = lo_buf_q;
    ram_addr_d  = ram_addr_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    acc_second  = 1'b0;
    ram_we      = '0;
    ram_wdata   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = size_e'(bus.req_size);
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (size_e'(bus.req_size) == SZ_X) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_ACC0;
          end
        end
      end

      ST_ACC0: begin
        ram_addr_d = word_w;
        if (we_q) begin
          ram_we    = st_mask;
          ram_wdata = st_wdata;
        end
        if (split) begin
          state_d = ST_ACC1;
        end else if (we_q) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = ST_FIN;
        end
      end

      ST_ACC1: begin
        acc_second = 1'b1;
        ram_addr_d = word_w + AWIDTH'(1);
        if (we_q) begin
          ram_we      = st_mask;
          ram_wdata   = st_wdata;
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          // Word W arrives now; word W+1 arrives in FIN.
          lo_buf_d = ram_rdata;
          state_d  = ST_FIN;
        end
      end

      default: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        state_d     = ST_IDLE;
      end
    endcase

    ram_addr = ram_addr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_buf_q    <= '0;
      ram_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_buf_q    <= lo_buf_d;
      ram_addr_q  <= ram_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Byte/halfword/word load-store alignment unit between the MemoryAccess stage control and the byte-write-enable data RAM (`bytewrite_ram_1b`, 32-bit word, 1-cycle registered read, read-first). It accepts byte-addressed requests, generates word address, byte enables and shifted write data, and returns extracted, sign- or zero-extended load data. Accesses that cross a word boundary are split into two RAM accesses by a small FSM.

## Interface
- `AWIDTH`, from `core_general.vh`: RAM word-address width.
- `DWIDTH`, 32: data width; fixed at 4 byte lanes.
- `clk` in 1: global clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `req_addr` in AWIDTH+2: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: qualified by `rsp_valid`; set for size 11.
- `ram_addr` out AWIDTH: word address to RAM.
- `ram_we` out 4: per-byte write enable.
- `ram_wdata` out 32: lane-aligned write data.
- `ram_rdata` in 32: RAM read data, valid one cycle after `ram_addr`.

## Operation
- Handshake: transfer when `req_valid && req_ready`. Request fields are latched at the transfer; later input changes are ignored.
- Decode: W = `req_addr[AWIDTH+1:2]`, off = `req_addr[1:0]`, n = 1/2/4 bytes.
- Split access: when off+n > 4. A byte access never splits.
- Second word address: W+1 modulo 2^AWIDTH, so the top word wraps to word 0.
- Lane mapping: byte k of the access goes to global byte off+k.
  - First access covers lanes off..min(3, off+n-1).
  - Second access covers lanes 0..(off+n-5).
  - `ram_wdata` = data rotated left by 8·off. `ram_we` = the lane mask for the current access.
- FSM states:
  - IDLE: ready=1. On transfer, size 11 produces a registered `rsp_valid` with `rsp_err`=1 and no RAM activity; FSM stays in IDLE. Otherwise go to ACC0.
  - ACC0: drive first access.
    - Aligned store → IDLE, with `rsp_valid` registered.
    - Split (load or store) → ACC1.
    - Aligned load → FIN.
  - ACC1: drive second access at W+1.
    - Load: capture `ram_rdata` (word W) into `lo_buf`, then go to FIN.
    - Store: go to IDLE with `rsp_valid` registered.
  - FIN: `ram_we`=0. `ram_rdata` holds the last word. Assemble bytes: take lanes off.. from the first word (`lo_buf` if split, else `ram_rdata`) and the remaining bytes from lanes 0.. of the second word. Extend to 32 bits, register into `rsp_rdata`, pulse `rsp_valid`, go to IDLE.
- `ram_we` is 0 in every state except ACC0 and ACC1 of a store. `ram_addr` holds its last value when idle.
- Reset, including mid-operation:
  - State forced to IDLE.
  - `rsp_valid`, `rsp_err`, `rsp_rdata`, `ram_we`, `ram_addr`, `ram_wdata` and `lo_buf` all reset to 0.
  - The in-flight request is dropped with no response. A RAM write already clocked stays committed.

## Timing
- The transfer edge is T0.
- `ram_*` outputs are decoded from registered state and request fields; there is no combinational path from `req_*` to `ram_*`.
- Aligned store: write occurs at edge T1→T2; `rsp_valid` in cycle T2.
- Split store: writes at edges ending T1 and T2; `rsp_valid` in T3.
- Aligned load: read address in T1, data in T2; `rsp_valid`/`rsp_rdata` in T3.
- Split load: `rsp_valid` in T4.
- Illegal size: `rsp_valid`+`rsp_err` in T1.
- `req_ready` is high in the response cycle, so a new request may transfer in the same cycle `rsp_valid` is high.
- Peak throughput: one aligned store per 2 cycles.

## Structure
- Add to `core_general.vh`:
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`.
  - FSM state encodings `ST_IDLE`, `ST_ACC0`, `ST_ACC1`, `ST_FIN`.
- One sub-module, `mem_lane_align`: purely combinational. Contains store rotate/mask generation and load byte assembly plus extension. It is instanced once and shared by the store and load paths.

## Test plan
- Aligned word store 0xDEADBEEF @ byte 0x10 → T1 `ram_addr`=4, `ram_we`=1111; `rsp_valid` at T2. Word load @0x10 → `rsp_rdata`=0xDEADBEEF at T3.
- Byte load signed @0x13 with word 4 = 0x80112233 → 0xFFFFFF80. Same with `req_unsigned`=1 → 0x00000080.
- Half store 0xA1B2 @0x07 → T1 word 1, `ram_we`=1000, lane3=0xB2. T2 word 2, `ram_we`=0001, lane0=0xA1. Half load unsigned @0x07 → 0x0000A1B2 at T4.
- Word load @ top byte address 2^(AWIDTH+2)-2 → second access `ram_addr`=0 (wrap). Result is the upper half of the top word combined with the lower half of word 0.
- `req_size`=11 → `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 at T1; `ram_we` stays 0.
- Assert `rst` during ACC1 of a split store → next cycle IDLE, `ram_we`=0, no `rsp_valid`. The first-half write stays in RAM; the second half is not written.
